// File: rtl/demux_route_seq.sv
// Break-before-make sequencer feeding a 1-to-4 demux (a, s0, s1, en).
// Optional per-channel delivery counters: define DEMUX_ROUTE_SEQ_STATS_EN.
module demux_route_seq #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES  = 2,
  parameter int unsigned GUARD_CYCLES = 1,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned STAT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_data,
  input  logic [1:0] in_dest,
  input  logic       abort,
  output logic       a,
  output logic       s0,
  output logic       s1,
  output logic       en,
  output logic       busy
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat0,
  output logic [STAT_W-1:0] stat1,
  output logic [STAT_W-1:0] stat2,
  output logic [STAT_W-1:0] stat3
`endif
);

  if (SETUP_CYCLES < 1 || HOLD_CYCLES < 1 || STAT_W < 1 ||
      SETUP_CYCLES > 2**CNT_W || HOLD_CYCLES > 2**CNT_W ||
      GUARD_CYCLES > 2**CNT_W) begin : g_bad_param
    $error("demux_route_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE, GUARD} state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD =
    CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_q, idle_d;
  logic             a_q, a_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic             en_q, en_d;
  logic             accept;
  logic             go_guard;

  assign in_ready = idle_q & ~abort;
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != IDLE);
  assign a        = a_q;
  assign s0       = s0_q;
  assign s1       = s1_q;
  assign en       = en_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    a_d      = a_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    en_d     = en_q;
    go_guard = 1'b0;
    case (state_q)
      IDLE: begin
        idle_d = 1'b1;
        if (accept) begin
          a_d     = in_data;
          s0_d    = in_dest[0];
          s1_d    = in_dest[1];
          en_d    = 1'b0;
          idle_d  = 1'b0;
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (abort) begin
          go_guard = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = DRIVE;
          en_d    = 1'b1;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DRIVE: begin
        if (abort || cnt_q == '0) begin
          en_d     = 1'b0;
          go_guard = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          idle_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero-length guard collapses straight back to IDLE on the same edge.
    if (go_guard) begin
      if (GUARD_CYCLES == 0) begin
        state_d = IDLE;
        idle_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        state_d = GUARD;
        cnt_d   = GUARD_LD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idle_q  <= 1'b0;
      a_q     <= 1'b0;
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      a_q     <= a_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      en_q    <= en_d;
    end
  end

`ifdef DEMUX_ROUTE_SEQ_STATS_EN
  logic              delivered;
  logic [STAT_W-1:0] stat_q [4];
  logic [STAT_W-1:0] stat_d [4];

  assign delivered = (state_q == DRIVE) & ~abort & (cnt_q == '0);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (delivered && {s1_q, s0_q} == 2'(i) && stat_q[i] != '1) begin
        stat_d[i] = stat_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) stat_q[i] <= stat_d[i];
    end
  end

  assign stat0 = stat_q[0];
  assign stat1 = stat_q[1];
  assign stat2 = stat_q[2];
  assign stat3 = stat_q[3];
`endif

endmodule

// File: tb/tb_demux_route_seq.sv
// Self-checking bench for demux_route_seq: vector table, scoreboard of routed
// requests (popped on each en rising edge), and hand-written corner sequences.
module tb_demux_route_seq;

  localparam int S = 1;
  localparam int H = 2;
  localparam int G = 1;
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
  localparam int SW = 2;
`else
  localparam int SW = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_data;
  logic [1:0] in_dest;
  logic       abort;
  logic       a, s0, s1, en, busy;
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
  logic          stat_clr;
  logic [SW-1:0] stat0, stat1, stat2, stat3;
`endif

  demux_route_seq #(
    .SETUP_CYCLES(S),
    .HOLD_CYCLES (H),
    .GUARD_CYCLES(G),
    .CNT_W       (4),
    .STAT_W      (SW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_dest (in_dest),
    .abort   (abort),
    .a       (a),
    .s0      (s0),
    .s1      (s1),
    .en      (en),
    .busy    (busy)
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat0   (stat0),
    .stat1   (stat1),
    .stat2   (stat2),
    .stat3   (stat3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [2:0] sb[$];

  typedef struct {
    logic       data;
    logic [1:0] dest;
    logic       exp_a;
    logic       exp_s1;
    logic       exp_s0;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock edge; samples 1ns later and scores each en rising edge.
  task automatic step();
    logic en_prev;
    logic [2:0] exp;
    en_prev = en;
    @(posedge clk);
    #1;
    if (en && !en_prev) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", 1, 0);
      end else begin
        exp = sb.pop_front();
        chk("sb_route", {29'd0, a, s1, s0}, {29'd0, exp});
      end
    end
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      step();
    end
    chk("ready_wait", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    in_valid = 1'b1;
    in_data  = v.data;
    in_dest  = v.dest;
    sb.push_back({v.data, v.dest});
    step();
    in_valid = 1'b0;
    chk("vec_a", a, v.exp_a);
    chk("vec_s1", s1, v.exp_s1);
    chk("vec_s0", s0, v.exp_s0);
    chk("vec_en_setup", en, 0);
    chk("vec_busy", busy, 1);
    for (int k = 1; k <= S + H + G; k++) begin
      step();
      chk("vec_en_phase", en, (k >= S && k < S + H) ? 1 : 0);
      chk("vec_ready_phase", in_ready, (k == S + H + G) ? 1 : 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev_sel;
    logic [2:0] snap;
    logic       acc;
    int         cyc, last_acc, idx;

    vecs[0] = '{data: 1'b1, dest: 2'd2, exp_a: 1'b1, exp_s1: 1'b1, exp_s0: 1'b0};
    vecs[1] = '{data: 1'b0, dest: 2'd0, exp_a: 1'b0, exp_s1: 1'b0, exp_s0: 1'b0};
    vecs[2] = '{data: 1'b1, dest: 2'd3, exp_a: 1'b1, exp_s1: 1'b1, exp_s0: 1'b1};
    vecs[3] = '{data: 1'b0, dest: 2'd1, exp_a: 1'b0, exp_s1: 1'b0, exp_s0: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_dest = 2'd0; abort = 1'b0;
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    stat_clr = 1'b0;
`endif
    #12;
    chk("rst_outputs", {28'd0, a, s1, s0, en}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", in_ready, 0);
    step();
    chk("ready_after_release", in_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    chk("stat2_after_vecs", stat2, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_clr_all", {stat3, stat2, stat1, stat0}, 0);
`endif

    // Back-to-back with in_valid held high across dests 0..3.
    wait_ready();
    idx = 0; cyc = 0; last_acc = 0;
    in_valid = 1'b1; in_data = 1'b0; in_dest = 2'd0;
    prev_sel = {s1, s0};
    for (int k = 0; k < 40 && idx < 4; k++) begin
      acc = in_ready & in_valid;
      if (acc) sb.push_back({in_data, in_dest});
      step();
      cyc++;
      if ({s1, s0} != prev_sel) chk("b2b_en_on_sel_change", en, 0);
      prev_sel = {s1, s0};
      if (acc) begin
        chk("b2b_sel", {s1, s0}, in_dest);
        if (idx > 0) chk("b2b_period", cyc - last_acc, S + H + G + 1);
        last_acc = cyc;
        idx++;
        in_dest = idx[1:0];
        in_data = ~in_data;
        if (idx == 4) in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", idx, 4);
    wait_ready();
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    chk("b2b_stats", {stat3, stat2, stat1, stat0}, {2'd1, 2'd1, 2'd1, 2'd1});
`endif

    // Abort in the first DRIVE cycle.
    in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd1;
    sb.push_back({1'b1, 2'd1});
    step();
    in_valid = 1'b0;
    step();
    chk("abort_drive_en1", en, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_en_drop", en, 0);
    chk("abort_guard_busy", busy, 1);
    chk("abort_guard_ready", in_ready, 0);
    step();
    chk("abort_idle_ready", in_ready, 1);
    chk("abort_idle_busy", busy, 0);
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    chk("abort_stat1", stat1, 1);
`endif
    run_vec(vecs[1]);

    // Abort held in IDLE blocks acceptance.
    snap = {a, s1, s0};
    abort = 1'b1; in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd2;
    #1;
    chk("idle_abort_ready", in_ready, 0);
    step();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_hold", {29'd0, a, s1, s0}, {29'd0, snap});
    abort = 1'b0;
    #1;
    chk("idle_release_ready", in_ready, 1);
    sb.push_back({1'b1, 2'd2});
    step();
    in_valid = 1'b0;
    chk("idle_release_accept", busy, 1);
    chk("idle_release_route", {29'd0, a, s1, s0}, 32'h6);
    wait_ready();

    // Asynchronous reset in the middle of DRIVE.
    in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd3;
    sb.push_back({1'b1, 2'd3});
    step();
    in_valid = 1'b0;
    step();
    chk("mid_rst_en_before", en, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {28'd0, a, s1, s0, en}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    chk("mid_rst_stats", {stat3, stat2, stat1, stat0}, 0);
`endif
    #2 rst_n = 1'b1;
    step();
    chk("mid_rst_ready_after", in_ready, 1);

`ifdef DEMUX_ROUTE_SEQ_STATS_EN
    for (int k = 0; k < 5; k++) run_vec(vecs[2]);
    chk("stat3_saturate", stat3, 3);
    wait_ready();
    in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd3;
    sb.push_back({1'b1, 2'd3});
    step();
    in_valid = 1'b0;
    for (int k = 0; k < S + H - 1; k++) step();
    chk("clr_edge_en", en, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_beats_incr", stat3, 0);
    wait_ready();
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_route_seq.md
Name: demux_route_seq

Overview:
- Sequencer directly upstream of the 1-to-4 demultiplexer. Drives that demux's `a`, `s0`, `s1` and `en` inputs.
- Accepts one routing request per handshake: a data bit plus a 2-bit destination.
- Drives the demux with break-before-make timing: select settles with `en` low, `en` pulses for a fixed hold time, then a guard gap before the select may change.
- Guarantees no glitch pulse on any y0..y3 while the select lines move.

Parameters:
- SETUP_CYCLES, 1: cycles select/data are stable with en=0 before en rises; must be >=1.
- HOLD_CYCLES, 2: cycles en is held high; must be >=1.
- GUARD_CYCLES, 1: cycles en=0 after the pulse before a new request is accepted; 0 allowed (GUARD skipped).
- CNT_W, 4: width of the internal phase counter; must hold max(SETUP,HOLD,GUARD).
- STAT_W, 8: width of each per-channel delivery counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  sequencer can accept; combinational = idle_q & ~abort
- in_data  input  1  data bit to route
- in_dest  input  2  destination channel 0..3
- abort  input  1  synchronous cancel of current request
- a  output  1  registered data to demux
- s0  output  1  registered select LSB (= dest[0])
- s1  output  1  registered select MSB (= dest[1])
- en  output  1  registered demux enable
- busy  output  1  state != IDLE
- stat_clr  input  1  clear delivery counters (STATS only)
- stat0..stat3  output  STAT_W  per-channel delivery counts (STATS only)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (asynchronous, immediate): a=0, s0=0, s1=0, en=0, busy=0, idle_q=0 (so in_ready=0), state=IDLE, phase counter=0, stat0..3=0.
- First edge after rst_n deasserts: idle_q=1.
- Reset asserted mid-pulse: en drops at once. Nothing completes and no stat is incremented.
- States:
  - IDLE: idle_q=1. Accept = in_valid & in_ready on an edge.
  - On accept: latch a=in_data, s0=in_dest[0], s1=in_dest[1]; en=0; idle_q=0; go to SETUP.
  - SETUP: hold for SETUP_CYCLES cycles, en=0, then go to DRIVE.
  - DRIVE: en=1 for HOLD_CYCLES cycles.
  - GUARD: en=0, a/s0/s1 unchanged, for GUARD_CYCLES cycles, then IDLE with idle_q=1.
- Timing (accept at edge T):
  - en=1 registered at edge T+SETUP_CYCLES.
  - en=0 at edge T+SETUP_CYCLES+HOLD_CYCLES.
  - idle_q=1 at edge T+SETUP+HOLD+GUARD.
  - Minimum request period = SETUP+HOLD+GUARD+1 cycles (5 with defaults).
- a/s0/s1 change only on the accept edge. en is never 1 on the edge where select changes.
- in_valid/in_data/in_dest are ignored whenever idle_q=0. Requests are never queued.
- Abort:
  - In SETUP or DRIVE: at the next edge en=0 and state goes to GUARD. GUARD still runs in full; if GUARD_CYCLES=0, go straight to IDLE.
  - In GUARD: no effect.
  - In IDLE: in_ready is forced to 0, so an in_valid on the same cycle is not accepted.
- A pulse counts as delivered only if DRIVE runs all HOLD_CYCLES without abort.
- Phase counter loads N-1 on state entry, decrements, and exits at 0. No wrap.

Optional Feature:
- Macro: DEMUX_ROUTE_SEQ_STATS_EN.
- Defined:
  - stat_clr and stat0..stat3 exist.
  - On the edge a full DRIVE ends, stat[dest] increments by 1 and saturates at all-ones (no wrap).
  - stat_clr zeroes all four counters on the next edge and wins over a same-edge increment.
- Undefined: the stat ports and counters are absent. Core timing is identical.

Test Plan:
- Reset then single request: data=1, dest=2, defaults.
  - Expect in_ready=1 one edge after reset release.
  - After accept: s1=1, s0=0, a=1, en=0 for 1 cycle, en=1 for 2 cycles, en=0 for 1 guard cycle.
  - in_ready=1 again 4 edges after accept.
- Back-to-back: in_valid held high with dests 0,1,2,3.
  - Accepts are exactly 5 cycles apart.
  - en=0 on every select-change edge.
  - In STATS build: stat0..3=1 each.
- Abort during DRIVE (first en=1 cycle), dest=1.
  - en=0 on the next edge; GUARD 1 cycle; return to IDLE.
  - stat1 unchanged.
  - A subsequent request is accepted normally.
- Abort high in IDLE with in_valid=1.
  - in_ready=0 and no accept; outputs unchanged.
  - With abort released, accept on the following edge.
- rst_n pulsed low mid-DRIVE (async, between edges).
  - en, a, s0, s1 go 0 immediately.
  - busy=0 and stats cleared.
  - in_ready returns 1 one edge after release.
- STATS saturation with STAT_W=2.
  - 5 deliveries to dest 3 give stat3=3.
  - stat_clr asserted on a completion edge gives stat3=0.
